// File: rtl/hps2ip_ring_ctrl.sv
// hps2ip_ring_ctrl
// Consumer-side sequencer for the HPS-to-IP descriptor ring. While the ring
// holds work (pi != ci) it fetches one 32-byte descriptor per AXI read burst,
// passes the beats straight to the IP datapath, advances ci, and writes ci
// back to host memory after C_WB_BATCH descriptors or when the ring drains.
//
// Ports
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   dma_en                      ring enable
//   hps2ip_base/ci_base         ring base / ci writeback address (32B units)
//   hps2ip_mindex, hps2ip_pi    last valid index, producer index
//   hps2ip_ci                   consumer index
//   m_ar*/m_r*                  AXI read channel (one burst in flight)
//   desc_*                      descriptor beat stream to the datapath
//   m_aw*/m_w*/m_b*             AXI write channel for ci writeback
//
// state  | meaning
// IDLE   | sample pi/mindex, choose fetch, writeback or nothing
// AR     | read address presented, waiting for m_arready
// DATA   | descriptor beats passed through to desc_*
// AW_W   | writeback address and data presented independently
// RESP   | waiting for the write response
module hps2ip_ring_ctrl #(
    parameter int C_WB_BATCH = 4,
    parameter int C_BEATS    = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        dma_en,
    input  logic [31:5] hps2ip_base,
    input  logic [31:5] hps2ip_ci_base,
    input  logic [16:0] hps2ip_mindex,
    input  logic [15:0] hps2ip_pi,
    output logic [15:0] hps2ip_ci,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arlen,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [63:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [63:0] desc_data,
    output logic        desc_last,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [3:0] WB_BATCH = 4'(C_WB_BATCH);

    logic [2:0]  state;
    logic [15:0] ci;
    logic [15:0] mindex_q;
    logic [15:0] wb_ci;
    logic [3:0]  batch_cnt;
    logic [31:0] araddr_q;
    logic        aw_pend;
    logic        w_pend;

    logic [15:0] ci_next;
    logic [26:0] fetch_blk;
    logic [3:0]  batch_inc;
    logic        ring_empty;
    logic        last_hs;
    logic        aw_ok;
    logic        w_ok;

    // Bit 16 of mindex is carried by the CSR but has no meaning here.
    logic unused_mindex_msb;
    assign unused_mindex_msb = hps2ip_mindex[16];

    // mindex_q is captured when the fetch is launched so a CSR change during
    // a burst cannot alter the wrap point of the descriptor being consumed.
    assign ci_next    = (ci == mindex_q) ? 16'd0 : ci + 16'd1;
    assign fetch_blk  = hps2ip_base + {11'd0, ci};
    assign batch_inc  = batch_cnt + 4'd1;
    assign ring_empty = (hps2ip_pi == ci);
    assign last_hs    = (state == S_DATA) && m_rvalid && desc_ready && m_rlast;
    assign aw_ok      = !aw_pend || m_awready;
    assign w_ok       = !w_pend  || m_wready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            ci        <= '0;
            mindex_q  <= '0;
            wb_ci     <= '0;
            batch_cnt <= '0;
            araddr_q  <= '0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_en && !ring_empty) begin
                        state    <= S_AR;
                        araddr_q <= {fetch_blk, 5'h0};
                        mindex_q <= hps2ip_mindex[15:0];
                    end else if (batch_cnt != 4'd0) begin
                        state   <= S_AW_W;
                        wb_ci   <= ci;
                        aw_pend <= 1'b1;
                        w_pend  <= 1'b1;
                    end else if (!dma_en) begin
                        // Disabled and fully flushed: re-arm from index 0.
                        ci <= '0;
                    end
                end
                S_AR: begin
                    if (m_arready) state <= S_DATA;
                end
                S_DATA: begin
                    if (last_hs) begin
                        ci        <= ci_next;
                        batch_cnt <= batch_inc;
                        if (batch_inc == WB_BATCH) begin
                            state   <= S_AW_W;
                            wb_ci   <= ci_next;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_AW_W: begin
                    if (aw_pend && m_awready) aw_pend <= 1'b0;
                    if (w_pend && m_wready)   w_pend  <= 1'b0;
                    if (aw_ok && w_ok)        state   <= S_RESP;
                end
                S_RESP: begin
                    if (m_bvalid) begin
                        batch_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign hps2ip_ci  = ci;

    assign m_araddr   = araddr_q;
    assign m_arlen    = 4'(C_BEATS - 1);
    assign m_arvalid  = (state == S_AR);

    assign m_rready   = (state == S_DATA) && desc_ready;
    assign desc_valid = (state == S_DATA) && m_rvalid;
    assign desc_data  = m_rdata;
    assign desc_last  = (state == S_DATA) && m_rlast;

    assign m_awaddr   = {hps2ip_ci_base, 5'h0};
    assign m_awvalid  = (state == S_AW_W) && aw_pend;
    assign m_wvalid   = (state == S_AW_W) && w_pend;
    assign m_wlast    = m_wvalid;
    assign m_wdata    = {48'h0, wb_ci};
    assign m_bready   = (state == S_RESP);

endmodule

// File: tb/tb_hps2ip_ring_ctrl.sv
// Bench for hps2ip_ring_ctrl: randomized AXI slave timing and datapath
// backpressure, with expected fetch addresses and writeback values derived
// from the ring rules (walk from ci to pi, batch/drain writebacks).
module tb_hps2ip_ring_ctrl;

    localparam int WB = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic        dma_en;
    logic [26:0] base;
    logic [26:0] ci_base;
    logic [15:0] mindex;
    logic        mindex_msb;
    logic [15:0] hps2ip_pi;
    logic [15:0] hps2ip_ci;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] desc_data;
    logic        desc_last;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_bvalid;
    logic        m_bready;

    hps2ip_ring_ctrl #(.C_WB_BATCH(WB), .C_BEATS(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .dma_en(dma_en),
        .hps2ip_base(base), .hps2ip_ci_base(ci_base),
        .hps2ip_mindex({mindex_msb, mindex}), .hps2ip_pi(hps2ip_pi),
        .hps2ip_ci(hps2ip_ci),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .desc_data(desc_data), .desc_last(desc_last), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] model_ci = 16'd0;
    int          model_batch = 0;
    logic [31:0] exp_ar[$];
    logic [15:0] exp_wb[$];

    function automatic logic [15:0] step_idx(input logic [15:0] i);
        return (i == mindex) ? 16'd0 : i + 16'd1;
    endfunction

    task automatic plan(input logic [15:0] target);
        logic [26:0] blk;
        int guard;
        guard = 0;
        while (model_ci != target && guard < 1000) begin
            blk = base + 27'(model_ci);
            exp_ar.push_back({blk, 5'h0});
            model_batch++;
            model_ci = step_idx(model_ci);
            if (model_batch == WB) begin
                exp_wb.push_back(model_ci);
                model_batch = 0;
            end
            guard++;
        end
        if (model_batch > 0) begin
            exp_wb.push_back(model_ci);
            model_batch = 0;
        end
    endtask

    // ---------------- slave state / monitor ----------------
    logic        rd_active = 1'b0;
    logic [31:0] rd_addr = '0;
    int          beat = 0;
    int          beats_total = 0;
    logic        r_taken = 1'b0;
    logic        aw_done = 1'b0;
    logic        w_done = 1'b0;
    logic        ar_wait = 1'b0;
    logic [31:0] ar_last_addr = '0;
    logic        bp_mode = 1'b0;
    int          wcnt = 0;
    logic [31:0] e_ar;
    logic [15:0] e_wb;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                rd_active = 1'b0; beat = 0; r_taken = 1'b0;
                aw_done = 1'b0; w_done = 1'b0; ar_wait = 1'b0;
            end else begin
                if (rd_active) begin
                    check_val("rready_tracks", m_rready, desc_ready);
                    check_val("dvalid_pass", desc_valid, m_rvalid);
                    if (m_rvalid && m_rready) begin
                        check_val("desc_data", desc_data, {rd_addr, 32'(beat)});
                        check_val("desc_last", desc_last, beat == 3);
                        beats_total++;
                        beat++;
                        if (m_rlast) rd_active = 1'b0;
                    end
                end else if (desc_valid || m_rready) begin
                    check_val("rd_idle", {desc_valid, m_rready}, 2'b00);
                end
                r_taken = m_rvalid && m_rready;

                if (m_arvalid && ar_wait) check_val("ar_stable", m_araddr, ar_last_addr);
                ar_wait = m_arvalid && !m_arready;
                ar_last_addr = m_araddr;
                if (m_arvalid && m_arready) begin
                    check_val("arlen", m_arlen, 4'h3);
                    check_val("one_rd", rd_active, 1'b0);
                    check_val("ar_expected", exp_ar.size() > 0, 1'b1);
                    if (exp_ar.size() > 0) begin
                        e_ar = exp_ar.pop_front();
                        check_val("araddr", m_araddr, e_ar);
                    end
                    rd_addr = m_araddr; rd_active = 1'b1; beat = 0;
                end

                if (m_bready) begin
                    check_val("resp_after_both", aw_done && w_done, 1'b1);
                    if (m_bvalid) begin aw_done = 1'b0; w_done = 1'b0; end
                end
                if (m_awvalid && m_awready) begin
                    check_val("awaddr", m_awaddr, {ci_base, 5'h0});
                    check_val("aw_once", aw_done, 1'b0);
                    aw_done = 1'b1;
                end
                if (m_wvalid && m_wready) begin
                    check_val("wlast", m_wlast, 1'b1);
                    check_val("w_once", w_done, 1'b0);
                    check_val("wb_expected", exp_wb.size() > 0, 1'b1);
                    if (exp_wb.size() > 0) begin
                        e_wb = exp_wb.pop_front();
                        check_val("wdata", m_wdata, {48'h0, e_wb});
                    end
                    w_done = 1'b1;
                end
            end
        end
    end

    // ---------------- slave driver ----------------
    initial begin
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rlast = 0; desc_ready = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst) begin
                m_arready = 0; m_rvalid = 0; m_rlast = 0; desc_ready = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; wcnt = 0;
            end else begin
                m_arready = 1'($urandom_range(0, 1));
                if (!m_rvalid || r_taken) begin
                    m_rvalid = rd_active && ($urandom_range(0, 3) != 0);
                    m_rdata  = {rd_addr, 32'(beat)};
                    m_rlast  = (beat == 3);
                end
                if (w_done) wcnt++; else wcnt = 0;
                if (bp_mode) begin
                    desc_ready = ~desc_ready;
                    m_wready   = 1'b1;
                    m_awready  = w_done && (wcnt >= 5);
                end else begin
                    desc_ready = ($urandom_range(0, 3) != 0);
                    m_wready   = 1'($urandom_range(0, 1));
                    m_awready  = 1'($urandom_range(0, 1));
                end
                m_bvalid = aw_done && w_done && (m_bvalid || ($urandom_range(0, 1) == 1));
            end
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic wait_idle(input string tag);
        int n;
        logic done;
        done = 1'b0;
        for (n = 0; n < 1500 && !done; n++) begin
            @(posedge sys_clk);
            #1;
            done = exp_ar.size() == 0 && exp_wb.size() == 0 && hps2ip_ci == model_ci &&
                   !rd_active && !m_arvalid && !m_awvalid && !m_wvalid && !m_bready;
        end
        if (!done)
            check_val({tag, "_timeout"},
                      {exp_ar.size() != 0, exp_wb.size() != 0, hps2ip_ci != model_ci,
                       rd_active, m_arvalid, m_awvalid, m_wvalid, m_bready}, 8'h0);
        repeat (4) begin @(posedge sys_clk); #1; end
        check_val({tag, "_ci"}, hps2ip_ci, model_ci);
        check_val({tag, "_ar_left"}, exp_ar.size(), 0);
        check_val({tag, "_wb_left"}, exp_wb.size(), 0);
        exp_ar.delete();
        exp_wb.delete();
    endtask

    task automatic run_to(input string tag, input logic [15:0] target);
        plan(target);
        hps2ip_pi = target;
        dma_en = 1'b1;
        wait_idle(tag);
    endtask

    task automatic ring_off();
        dma_en = 1'b0;
        model_ci = 16'd0;
        wait_idle("ring_off");
    endtask

    task automatic wait_beats(input string tag, input int target);
        int n;
        for (n = 0; n < 500 && beats_total < target; n++) begin
            @(posedge sys_clk);
            #1;
        end
        if (beats_total < target) check_val({tag, "_beat_wait"}, 32'(beats_total), 32'(target));
    endtask

    // ---------------- main sequence ----------------
    int           start_beats;
    logic [15:0]  t;
    int           steps;

    initial begin
        sys_rst = 1'b1; dma_en = 1'b0; hps2ip_pi = '0;
        base = 27'h0800000; ci_base = 27'h0123456; mindex = 16'd7; mindex_msb = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_val("rst_ci", hps2ip_ci, 16'd0);
        check_val("rst_valids", {m_arvalid, m_rready, desc_valid, m_awvalid, m_wvalid, m_bready}, 6'h0);
        @(posedge sys_clk);
        #1;

        run_to("single", 16'd1);
        ring_off();
        run_to("batch", 16'd6);
        ring_off();

        mindex = 16'd3;
        run_to("wrap_pre", 16'd3);
        run_to("wrap", 16'd1);

        bp_mode = 1'b1;
        run_to("backpressure", 16'd0);
        bp_mode = 1'b0;

        // enable dropped during the second beat of the first descriptor
        mindex = 16'd7;
        ring_off();
        start_beats = beats_total;
        exp_ar.push_back({base, 5'h0});
        exp_wb.push_back(16'd1);
        model_ci = 16'd0;
        hps2ip_pi = 16'd3;
        dma_en = 1'b1;
        wait_beats("drop", start_beats + 2);
        dma_en = 1'b0;
        wait_idle("drop");
        check_val("drop_beats", 32'(beats_total - start_beats), 32'd4);

        // reset during a descriptor, then restart from index 0
        hps2ip_pi = 16'd4;
        dma_en = 1'b1;
        exp_ar.push_back({base, 5'h0});
        start_beats = beats_total;
        wait_beats("rst", start_beats + 1);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        exp_ar.delete();
        exp_wb.delete();
        hps2ip_pi = 16'd2;
        model_ci = 16'd0;
        model_batch = 0;
        plan(16'd2);
        @(negedge sys_clk);
        check_val("mid_rst_ci", hps2ip_ci, 16'd0);
        check_val("mid_rst_valids", {m_arvalid, m_rready, desc_valid, m_awvalid, m_wvalid, m_bready}, 6'h0);
        wait_idle("after_rst");

        for (int k = 0; k < 24; k++) begin
            bp_mode = 1'($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                ring_off();
                mindex = 16'($urandom_range(1, 12));
                mindex_msb = 1'($urandom_range(0, 1));
                ci_base = 27'($urandom);
                if ($urandom_range(0, 1) == 1) base = 27'h7FFFFFF - 27'($urandom_range(0, 8));
                else base = 27'($urandom);
            end
            steps = $urandom_range(0, 32'(mindex));
            t = model_ci;
            repeat (steps) t = step_idx(t);
            run_to("rand", t);
        end
        bp_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
